// File: rtl/rf_rename_ctrl.sv
// ---------------------------------------------------------------------------
// rf_rename_ctrl
//   Rename-status controller for the architectural register file. It keeps a
//   busy bit and a producing ROB tag for every register. Issue renames rd.
//   Commit clears the rename only when the retiring tag is still the current
//   producer. Commit values go out on a registered RF write port. RS operand
//   lookups are resolved combinationally, with bypass from the commit port
//   and from the pending RF write.
//
// Ports
//   i_clk, i_rst (sync, active-low), i_rdy (global enable, 0 freezes state)
//   i_issue_valid / i_issue_rd / i_issue_tag        : rename request
//   i_commit_valid / i_commit_rd / i_commit_tag /
//   i_commit_val                                    : ROB retirement
//   i_flush                                         : discard all renames
//   i_rs1 / i_rs2, i_rf_rs1_val / i_rf_rs2_val      : operand lookup inputs
//   o_rsN_ready / o_rsN_tag / o_rsN_val             : operand lookup results
//   o_rf_we / o_rf_waddr / o_rf_wdata               : registered RF write
//   o_busy_count                                    : renamed register count
// ---------------------------------------------------------------------------
module rf_rename_ctrl #(
    parameter int ROB_W = 4,
    parameter int REG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rdy,
    input  logic             i_issue_valid,
    input  logic [REG_W-1:0] i_issue_rd,
    input  logic [ROB_W-1:0] i_issue_tag,
    input  logic             i_commit_valid,
    input  logic [REG_W-1:0] i_commit_rd,
    input  logic [ROB_W-1:0] i_commit_tag,
    input  logic [31:0]      i_commit_val,
    input  logic             i_flush,
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    input  logic [31:0]      i_rf_rs1_val,
    input  logic [31:0]      i_rf_rs2_val,
    output logic             o_rs1_ready,
    output logic [ROB_W-1:0] o_rs1_tag,
    output logic [31:0]      o_rs1_val,
    output logic             o_rs2_ready,
    output logic [ROB_W-1:0] o_rs2_tag,
    output logic [31:0]      o_rs2_val,
    output logic             o_rf_we,
    output logic [REG_W-1:0] o_rf_waddr,
    output logic [31:0]      o_rf_wdata,
    output logic [REG_W:0]   o_busy_count
);

    localparam int NREG = 2 ** REG_W;

    typedef struct packed {
        logic             ready;
        logic [ROB_W-1:0] tag;
        logic [31:0]      val;
    } lookup_t;

    logic [NREG-1:0]  r_busy;
    logic [ROB_W-1:0] r_tag [NREG];
    logic             r_rf_we;
    logic [REG_W-1:0] r_rf_waddr;
    logic [31:0]      r_rf_wdata;
    logic [REG_W:0]   r_busy_count;

    logic [NREG-1:0]  w_busy_nxt;
    logic [ROB_W-1:0] w_tag_nxt [NREG];
    logic [REG_W:0]   w_count_nxt;
    logic             w_commit_hit;
    logic             w_issue_en;
    lookup_t          w_lk1;
    lookup_t          w_lk2;

    // Only a commit from the current producer may release the rename; an
    // older instance of the same rd retiring must leave the newer one alone.
    assign w_commit_hit = i_commit_valid && r_busy[i_commit_rd] &&
                          (r_tag[i_commit_rd] == i_commit_tag);
    assign w_issue_en   = i_issue_valid && (i_issue_rd != '0);

    // NOTE: every variable in a combinational block gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_busy_nxt = r_busy;
        w_tag_nxt  = r_tag;
        if (i_flush) begin
            w_busy_nxt = '0;
            for (int i = 0; i < NREG; i++) w_tag_nxt[i] = '0;
        end else begin
            if (w_commit_hit) w_busy_nxt[i_commit_rd] = 1'b0;
            // Applied after the commit clear so a same-rd issue wins.
            if (w_issue_en) begin
                w_busy_nxt[i_issue_rd] = 1'b1;
                w_tag_nxt[i_issue_rd]  = i_issue_tag;
            end
        end
    end

    // The count always equals the population of the busy vector, which is
    // the net of all 0->1 and 1->0 transitions. x0 never becomes busy, so
    // the count tops out at NREG-1.
    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < NREG; i++)
            w_count_nxt = w_count_nxt + (REG_W+1)'(w_busy_nxt[i]);
    end

    // NOTE: the tag array is a small flop array that must read as zero after
    // reset, so it is cleared explicitly rather than left to power-up state.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_busy       <= '0;
            for (int i = 0; i < NREG; i++) r_tag[i] <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_busy_count <= '0;
        end else if (i_rdy) begin
            r_busy       <= w_busy_nxt;
            r_tag        <= w_tag_nxt;
            r_busy_count <= w_count_nxt;
            // Commits are written even during a flush; x0 writes are masked.
            r_rf_we      <= i_commit_valid && (i_commit_rd != '0);
            if (i_commit_valid) begin
                r_rf_waddr <= i_commit_rd;
                r_rf_wdata <= i_commit_val;
            end
        end else begin
            r_rf_we <= 1'b0;
        end
    end

    // Operand resolution in priority order: x0, not renamed (with bypass of
    // the RF write still in flight), committing this cycle, else wait on tag.
    function automatic lookup_t do_lookup(input logic [REG_W-1:0] rs,
                                          input logic [31:0]      rf_val);
        lookup_t res;
        res.ready = 1'b0;
        res.tag   = r_tag[rs];
        res.val   = '0;
        if (rs == '0) begin
            res.ready = 1'b1;
            res.tag   = '0;
        end else if (!r_busy[rs]) begin
            res.ready = 1'b1;
            res.val   = (r_rf_we && (r_rf_waddr == rs)) ? r_rf_wdata : rf_val;
        end else if (i_commit_valid && (i_commit_rd == rs) &&
                     (i_commit_tag == r_tag[rs])) begin
            res.ready = 1'b1;
            res.val   = i_commit_val;
        end
        return res;
    endfunction

    always_comb begin
        w_lk1 = do_lookup(i_rs1, i_rf_rs1_val);
        w_lk2 = do_lookup(i_rs2, i_rf_rs2_val);
    end

    assign o_rs1_ready  = w_lk1.ready;
    assign o_rs1_tag    = w_lk1.tag;
    assign o_rs1_val    = w_lk1.val;
    assign o_rs2_ready  = w_lk2.ready;
    assign o_rs2_tag    = w_lk2.tag;
    assign o_rs2_val    = w_lk2.val;
    assign o_rf_we      = r_rf_we;
    assign o_rf_waddr   = r_rf_waddr;
    assign o_rf_wdata   = r_rf_wdata;
    assign o_busy_count = r_busy_count;

endmodule

// File: tb/tb_rf_rename_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rf_rename_ctrl
//   Self-checking bench for rf_rename_ctrl: directed scenarios followed by a
//   randomized run checked against a behavioural rename-table model.
// ---------------------------------------------------------------------------
module tb_rf_rename_ctrl;

    logic        clk;
    logic        rst, rdy, issue_valid, commit_valid, flush;
    logic [4:0]  issue_rd, commit_rd, rs1, rs2;
    logic [3:0]  issue_tag, commit_tag;
    logic [31:0] commit_val, rf_rs1_val, rf_rs2_val;
    logic        rs1_ready, rs2_ready, rf_we;
    logic [3:0]  rs1_tag, rs2_tag;
    logic [31:0] rs1_val, rs2_val, rf_wdata;
    logic [4:0]  rf_waddr;
    logic [5:0]  busy_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the rename table and the RF write port.
    bit          m_busy [32];
    int unsigned m_tag  [32];
    bit          m_we;
    int unsigned m_waddr;
    logic [31:0] m_wdata;

    rf_rename_ctrl #(.ROB_W(4), .REG_W(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_rdy(rdy),
        .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .i_issue_tag(issue_tag),
        .i_commit_valid(commit_valid), .i_commit_rd(commit_rd),
        .i_commit_tag(commit_tag), .i_commit_val(commit_val),
        .i_flush(flush), .i_rs1(rs1), .i_rs2(rs2),
        .i_rf_rs1_val(rf_rs1_val), .i_rf_rs2_val(rf_rs2_val),
        .o_rs1_ready(rs1_ready), .o_rs1_tag(rs1_tag), .o_rs1_val(rs1_val),
        .o_rs2_ready(rs2_ready), .o_rs2_tag(rs2_tag), .o_rs2_val(rs2_val),
        .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
        .o_busy_count(busy_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run still active at time %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic void m_lookup(input int rs, input logic [31:0] rfv,
                                     output bit r, output int unsigned t,
                                     output logic [31:0] v);
        r = 1'b0; t = m_tag[rs]; v = 32'h0;
        if (rs == 0) begin
            r = 1'b1; t = 0;
        end else if (!m_busy[rs]) begin
            r = 1'b1;
            v = (m_we && m_waddr == rs) ? m_wdata : rfv;
        end else if (commit_valid && commit_rd == rs && commit_tag == m_tag[rs]) begin
            r = 1'b1; v = commit_val;
        end
    endfunction

    // Applies one clock edge of the architectural rules to the model.
    task automatic model_update();
        bit hit;
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
            m_we = 0; m_waddr = 0; m_wdata = 0;
        end else if (rdy) begin
            hit  = commit_valid && m_busy[commit_rd] && m_tag[commit_rd] == commit_tag;
            m_we = commit_valid && commit_rd != 0;
            if (commit_valid) begin m_waddr = commit_rd; m_wdata = commit_val; end
            if (flush) begin
                for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
            end else begin
                if (hit) m_busy[commit_rd] = 0;
                if (issue_valid && issue_rd != 0) begin
                    m_busy[issue_rd] = 1; m_tag[issue_rd] = issue_tag;
                end
            end
        end else begin
            m_we = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 1; rdy = 1; flush = 0;
        issue_valid = 0; issue_rd = 0; issue_tag = 0;
        commit_valid = 0; commit_rd = 0; commit_tag = 0; commit_val = 0;
        rs1 = 0; rs2 = 0; rf_rs1_val = 0; rf_rs2_val = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 0; issue_valid = 1; issue_rd = 3; issue_tag = 7;
        commit_valid = 1; commit_rd = 4; commit_tag = 2; commit_val = 32'hA5A5A5A5;
        flush = 0;
        tick(); tick();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %0h want 0", rf_we); else n_pass++;
        n_checks++; if (rf_waddr !== 5'd0) $display("FAIL reset_waddr: got %0h want 0", rf_waddr); else n_pass++;
        n_checks++; if (rf_wdata !== 32'h0) $display("FAIL reset_wdata: got %0h want 0", rf_wdata); else n_pass++;
        n_checks++; if (busy_count !== 6'd0) $display("FAIL reset_count: got %0d want 0", busy_count); else n_pass++;
        rs1 = 5; rf_rs1_val = 32'hCAFE0005; #1;
        n_checks++; if (rs1_ready !== 1'b1) $display("FAIL reset_rs1_ready: got %0h want 1", rs1_ready); else n_pass++;
        n_checks++; if (rs1_val !== 32'hCAFE0005) $display("FAIL reset_rs1_val: got %0h want cafe0005", rs1_val); else n_pass++;
        idle(); tick();
    endtask

    task automatic test_issue_commit();
        idle(); issue_valid = 1; issue_rd = 3; issue_tag = 7; tick();
        idle(); rs1 = 3; rf_rs1_val = 32'h12121212; #1;
        n_checks++; if (rs1_ready !== 1'b0) $display("FAIL ic_pending_ready: got %0h want 0", rs1_ready); else n_pass++;
        n_checks++; if (rs1_tag !== 4'd7) $display("FAIL ic_pending_tag: got %0h want 7", rs1_tag); else n_pass++;
        n_checks++; if (rs1_val !== 32'h0) $display("FAIL ic_pending_val: got %0h want 0", rs1_val); else n_pass++;
        commit_valid = 1; commit_rd = 3; commit_tag = 7; commit_val = 32'hDEADBEEF; #1;
        n_checks++; if (rs1_ready !== 1'b1) $display("FAIL ic_bypass_ready: got %0h want 1", rs1_ready); else n_pass++;
        n_checks++; if (rs1_val !== 32'hDEADBEEF) $display("FAIL ic_bypass_val: got %0h want deadbeef", rs1_val); else n_pass++;
        tick();
        idle(); rs1 = 3; rf_rs1_val = 32'h11111111; #1;
        n_checks++; if (rf_we !== 1'b1) $display("FAIL ic_we: got %0h want 1", rf_we); else n_pass++;
        n_checks++; if (rf_waddr !== 5'd3) $display("FAIL ic_waddr: got %0h want 3", rf_waddr); else n_pass++;
        n_checks++; if (rf_wdata !== 32'hDEADBEEF) $display("FAIL ic_wdata: got %0h want deadbeef", rf_wdata); else n_pass++;
        n_checks++; if (busy_count !== 6'd0) $display("FAIL ic_count: got %0d want 0", busy_count); else n_pass++;
        n_checks++; if (rs1_val !== 32'hDEADBEEF) $display("FAIL ic_wb_bypass: got %0h want deadbeef", rs1_val); else n_pass++;
        tick();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL ic_we_drop: got %0h want 0", rf_we); else n_pass++;
        n_checks++; if (rf_waddr !== 5'd3) $display("FAIL ic_waddr_hold: got %0h want 3", rf_waddr); else n_pass++;
        n_checks++; if (rs1_val !== 32'h11111111) $display("FAIL ic_rf_read: got %0h want 11111111", rs1_val); else n_pass++;
    endtask

    task automatic test_stale_commit();
        idle(); issue_valid = 1; issue_rd = 4; issue_tag = 1; tick();
        issue_tag = 2; tick();
        idle(); commit_valid = 1; commit_rd = 4; commit_tag = 1; commit_val = 32'h44; tick();
        idle(); rs2 = 4; #1;
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4) $display("FAIL stale_write: got we=%0h addr=%0h want 1/4", rf_we, rf_waddr); else n_pass++;
        n_checks++; if (busy_count !== 6'd1) $display("FAIL stale_count: got %0d want 1", busy_count); else n_pass++;
        n_checks++; if (rs2_ready !== 1'b0 || rs2_tag !== 4'd2) $display("FAIL stale_rename: got ready=%0h tag=%0h want 0/2", rs2_ready, rs2_tag); else n_pass++;
        idle(); commit_valid = 1; commit_rd = 4; commit_tag = 2; tick();
        idle(); #1;
        n_checks++; if (busy_count !== 6'd0) $display("FAIL stale_release: got %0d want 0", busy_count); else n_pass++;
    endtask

    task automatic test_same_cycle();
        idle(); issue_valid = 1; issue_rd = 6; issue_tag = 5; tick();
        idle(); issue_valid = 1; issue_rd = 6; issue_tag = 9;
        commit_valid = 1; commit_rd = 6; commit_tag = 5; commit_val = 32'h66; tick();
        idle(); rs1 = 6; #1;
        n_checks++; if (rs1_ready !== 1'b0 || rs1_tag !== 4'd9) $display("FAIL same_rename: got ready=%0h tag=%0h want 0/9", rs1_ready, rs1_tag); else n_pass++;
        n_checks++; if (busy_count !== 6'd1) $display("FAIL same_count: got %0d want 1", busy_count); else n_pass++;
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h66) $display("FAIL same_write: got we=%0h addr=%0h data=%0h want 1/6/66", rf_we, rf_waddr, rf_wdata); else n_pass++;
    endtask

    task automatic test_flush();
        idle(); flush = 1; tick();
        n_checks++; if (busy_count !== 6'd0) $display("FAIL flush_clear: got %0d want 0", busy_count); else n_pass++;
        for (int r = 1; r <= 3; r++) begin
            idle(); issue_valid = 1; issue_rd = 5'(r); issue_tag = 4'(r); tick();
        end
        n_checks++; if (busy_count !== 6'd3) $display("FAIL flush_pre_count: got %0d want 3", busy_count); else n_pass++;
        idle(); flush = 1; commit_valid = 1; commit_rd = 2; commit_tag = 2; commit_val = 32'h22;
        issue_valid = 1; issue_rd = 5; issue_tag = 3; tick();
        idle(); rs1 = 1; rs2 = 5; rf_rs1_val = 32'h101; rf_rs2_val = 32'h505; #1;
        n_checks++; if (busy_count !== 6'd0) $display("FAIL flush_count: got %0d want 0", busy_count); else n_pass++;
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h22) $display("FAIL flush_write: got we=%0h addr=%0h data=%0h want 1/2/22", rf_we, rf_waddr, rf_wdata); else n_pass++;
        n_checks++; if (rs1_ready !== 1'b1 || rs1_val !== 32'h101) $display("FAIL flush_rs1: got ready=%0h val=%0h want 1/101", rs1_ready, rs1_val); else n_pass++;
        n_checks++; if (rs2_ready !== 1'b1 || rs2_val !== 32'h505) $display("FAIL flush_drop_issue: got ready=%0h val=%0h want 1/505", rs2_ready, rs2_val); else n_pass++;
        idle(); issue_valid = 1; issue_rd = 0; issue_tag = 3;
        commit_valid = 1; commit_rd = 0; commit_tag = 3; commit_val = 32'h99; tick();
        idle(); rs1 = 0; #1;
        n_checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0) $display("FAIL x0_write: got we=%0h addr=%0h want 0/0", rf_we, rf_waddr); else n_pass++;
        n_checks++; if (busy_count !== 6'd0) $display("FAIL x0_count: got %0d want 0", busy_count); else n_pass++;
        n_checks++; if (rs1_ready !== 1'b1 || rs1_val !== 32'h0) $display("FAIL x0_lookup: got ready=%0h val=%0h want 1/0", rs1_ready, rs1_val); else n_pass++;
    endtask

    task automatic test_rdy_and_reset();
        idle(); issue_valid = 1; issue_rd = 7; issue_tag = 1; tick();
        idle(); rdy = 0; issue_valid = 1; issue_rd = 8; issue_tag = 2;
        commit_valid = 1; commit_rd = 7; commit_tag = 1; commit_val = 32'h77; tick();
        idle(); rdy = 0; rs1 = 8; rs2 = 7; #1;
        n_checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0) $display("FAIL rdy_we: got we=%0h addr=%0h want 0/0", rf_we, rf_waddr); else n_pass++;
        n_checks++; if (busy_count !== 6'd1) $display("FAIL rdy_count: got %0d want 1", busy_count); else n_pass++;
        n_checks++; if (rs1_ready !== 1'b1) $display("FAIL rdy_no_issue: got %0h want 1", rs1_ready); else n_pass++;
        n_checks++; if (rs2_ready !== 1'b0 || rs2_tag !== 4'd1) $display("FAIL rdy_no_commit: got ready=%0h tag=%0h want 0/1", rs2_ready, rs2_tag); else n_pass++;
        idle(); commit_valid = 1; commit_rd = 9; commit_val = 32'h99; tick();
        idle(); rst = 0; issue_valid = 1; issue_rd = 9; issue_tag = 4; tick();
        idle(); rs2 = 7; #1;
        n_checks++; if (busy_count !== 6'd0 || rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0) $display("FAIL midrst: got cnt=%0d we=%0h addr=%0h data=%0h want 0/0/0/0", busy_count, rf_we, rf_waddr, rf_wdata); else n_pass++;
        n_checks++; if (rs2_ready !== 1'b1) $display("FAIL midrst_ready: got %0h want 1", rs2_ready); else n_pass++;
    endtask

    task automatic test_fill();
        for (int r = 1; r < 32; r++) begin
            idle(); issue_valid = 1; issue_rd = 5'(r); issue_tag = 4'(r % 16); tick();
        end
        idle(); issue_valid = 1; issue_rd = 0; tick();
        idle(); #1;
        n_checks++; if (busy_count !== 6'd31) $display("FAIL fill_count: got %0d want 31", busy_count); else n_pass++;
        idle(); flush = 1; tick();
        n_checks++; if (busy_count !== 6'd0) $display("FAIL fill_flush: got %0d want 0", busy_count); else n_pass++;
    endtask

    task automatic test_random();
        bit          er;
        int unsigned et;
        logic [31:0] ev;
        idle(); rst = 0; tick();
        for (int c = 0; c < 1500; c++) begin
            rst          = ($urandom_range(0, 99) != 0);
            rdy          = ($urandom_range(0, 7) != 0);
            flush        = ($urandom_range(0, 31) == 0);
            issue_valid  = $urandom_range(0, 1);
            issue_rd     = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            issue_tag    = 4'($urandom);
            commit_valid = $urandom_range(0, 1);
            commit_rd    = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            commit_tag   = $urandom_range(0, 1) ? 4'(m_tag[commit_rd]) : 4'($urandom);
            commit_val   = $urandom;
            rs1          = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rs2          = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rf_rs1_val   = $urandom;
            rf_rs2_val   = $urandom;
            #1;
            m_lookup(rs1, rf_rs1_val, er, et, ev);
            n_checks++;
            if (rs1_ready !== er || rs1_val !== ev || (rs1 != 0 && rs1_tag !== 4'(et)))
                $display("FAIL rnd_rs1 c=%0d: got r=%0h t=%0h v=%0h want r=%0h t=%0h v=%0h", c, rs1_ready, rs1_tag, rs1_val, er, et, ev);
            else n_pass++;
            m_lookup(rs2, rf_rs2_val, er, et, ev);
            n_checks++;
            if (rs2_ready !== er || rs2_val !== ev || (rs2 != 0 && rs2_tag !== 4'(et)))
                $display("FAIL rnd_rs2 c=%0d: got r=%0h t=%0h v=%0h want r=%0h t=%0h v=%0h", c, rs2_ready, rs2_tag, rs2_val, er, et, ev);
            else n_pass++;
            tick();
            n_checks++;
            if (rf_we !== m_we || rf_waddr !== 5'(m_waddr) || rf_wdata !== m_wdata || busy_count !== 6'(m_count()))
                $display("FAIL rnd_regs c=%0d: got we=%0h a=%0h d=%0h n=%0d want we=%0h a=%0h d=%0h n=%0d", c, rf_we, rf_waddr, rf_wdata, busy_count, m_we, m_waddr, m_wdata, m_count());
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
        m_we = 0; m_waddr = 0; m_wdata = 0;
        idle();
        #1;
        test_reset();
        test_issue_commit();
        test_stale_commit();
        test_same_cycle();
        test_flush();
        test_rdy_and_reset();
        test_fill();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
